// File: rtl/pe_checker_pkg.sv
// pe_checker_pkg: shared defaults, derived result width and FSM encoding for pe_checker
package pe_checker_pkg;
   localparam int A_DEF       = 8;
   localparam int B_DEF       = 8;
   localparam int LAT_DEF     = 2;
   localparam int NUM_VEC_DEF = 16;

   // Three A x B products summed need two extra bits to never truncate.
   function automatic int out_w(input int a, input int b);
      return a + b + 2;
   endfunction

   localparam int OUT_W_DEF = out_w(A_DEF, B_DEF);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/pe_ref_dot3.sv
// pe_ref_dot3: combinational 3-lane unsigned dot product used as the reference result
// Ports:
//   a   - three packed unsigned A-bit lanes, lane0 = a[A-1:0]
//   b   - three packed unsigned B-bit lanes, lane0 = b[B-1:0]
//   dot - a0*b0 + a1*b1 + a2*b2, W bits wide
module pe_ref_dot3
   import pe_checker_pkg::*;
#(
   parameter int A = A_DEF,
   parameter int B = B_DEF,
   parameter int W = OUT_W_DEF
) (
   input  logic [3*A-1:0] a,
   input  logic [3*B-1:0] b,
   output logic [W-1:0]   dot
);
   always_comb begin
      dot = '0;
      for (int i = 0; i < 3; i++)
         dot = dot + W'(a[i*A +: A]) * W'(b[i*B +: B]);
   end
endmodule

// File: rtl/pe_checker.sv
// pe_checker: compares a PE's 3-lane dot-product result against a delayed reference
// Ports:
//   i_clk, i_resetn       - clock, synchronous active-low reset
//   i_start               - pulse that begins a run from IDLE or DONE
//   i_valid               - pe_mul_a/pe_mul_b carry a vector this cycle
//   pe_mul_a, pe_mul_b    - packed operand lanes, lane0 in the low bits
//   pe_out                - PE result, expected LAT cycles after its vector
//   o_mismatch            - one-cycle pulse after a failed compare
//   o_cmp_cnt, o_err_cnt  - compares done / mismatches seen in this run
//   o_done, o_pass        - run finished / finished with no mismatch
//   o_first_err_idx       - o_cmp_cnt at the first mismatch
// Build option: define PE_CHECKER_FIRST_ERR_EN to capture o_first_err_idx,
// otherwise it is tied to 0.
module pe_checker
   import pe_checker_pkg::*;
#(
   parameter  int A       = A_DEF,
   parameter  int B       = B_DEF,
   parameter  int LAT     = LAT_DEF,
   parameter  int NUM_VEC = NUM_VEC_DEF,
   localparam int W       = out_w(A, B)
) (
   input  logic           i_clk,
   input  logic           i_resetn,
   input  logic           i_start,
   input  logic           i_valid,
   input  logic [3*A-1:0] pe_mul_a,
   input  logic [3*B-1:0] pe_mul_b,
   input  logic [W-1:0]   pe_out,
   output logic           o_mismatch,
   output logic [7:0]     o_cmp_cnt,
   output logic [7:0]     o_err_cnt,
   output logic           o_done,
   output logic           o_pass,
   output logic [7:0]     o_first_err_idx
);
   localparam logic [7:0] NV = 8'(NUM_VEC);

   state_t       state_q, state_d;
   logic [W-1:0] exp_now;
   logic [W-1:0] exp_q [LAT];
   logic         vld_q [LAT];
   logic [7:0]   acc_cnt;
   logic         in_run, start_run, accept, cmp, miss;

   pe_ref_dot3 #(.A(A), .B(B), .W(W)) u_dot (
      .a   (pe_mul_a),
      .b   (pe_mul_b),
      .dot (exp_now)
   );

   assign in_run    = state_q == RUN;
   assign start_run = !in_run && i_start;
   assign accept    = in_run && i_valid && acc_cnt < NV;
   assign cmp       = in_run && vld_q[LAT-1];
   assign miss      = cmp && pe_out != exp_q[LAT-1];
   assign o_done    = state_q == DONE;
   assign o_pass    = o_done && o_err_cnt == 8'd0;

   // Every accepted vector is compared before o_cmp_cnt can reach NV,
   // so the run closes one cycle after the final compare lands.
   always_comb begin
      state_d = in_run ? ((o_cmp_cnt == NV) ? DONE : RUN) : (i_start ? RUN : state_q);
   end

   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         state_q    <= IDLE;
         acc_cnt    <= '0;
         o_cmp_cnt  <= '0;
         o_err_cnt  <= '0;
         o_mismatch <= 1'b0;
      end else begin
         state_q    <= state_d;
         o_mismatch <= miss;
         if (start_run) begin
            acc_cnt   <= '0;
            o_cmp_cnt <= '0;
            o_err_cnt <= '0;
         end else begin
            acc_cnt   <= acc_cnt + 8'(accept);
            o_cmp_cnt <= o_cmp_cnt + 8'(cmp);
            if (miss && o_err_cnt != 8'hff)
               o_err_cnt <= o_err_cnt + 8'd1;
         end
      end
   end

   // Valid bits mark real vectors; clearing them on reset or start drops
   // anything still in flight so it is never compared.
   always_ff @(posedge i_clk) begin
      if (!i_resetn || start_run) begin
         for (int i = 0; i < LAT; i++)
            vld_q[i] <= 1'b0;
      end else begin
         vld_q[0] <= accept;
         for (int i = 1; i < LAT; i++)
            vld_q[i] <= vld_q[i-1];
      end
   end

   always_ff @(posedge i_clk) begin
      exp_q[0] <= exp_now;
      for (int i = 1; i < LAT; i++)
         exp_q[i] <= exp_q[i-1];
   end

`ifdef PE_CHECKER_FIRST_ERR_EN
   // o_err_cnt == 0 identifies the first mismatch; it saturates, never wraps.
   always_ff @(posedge i_clk) begin
      if (!i_resetn || start_run)
         o_first_err_idx <= '0;
      else if (miss && o_err_cnt == 8'd0)
         o_first_err_idx <= o_cmp_cnt;
   end
`else
   assign o_first_err_idx = '0;
`endif
endmodule

// File: tb/tb_pe_checker.sv
// tb_pe_checker: randomized self-checking bench for pe_checker against a schedule-based model
`timescale 1ns/1ps
module tb_pe_checker;
   localparam int A   = 8;
   localparam int B   = 8;
   localparam int LAT = 2;
   localparam int W   = A + B + 2;

   logic           clk = 1'b0, resetn = 1'b0, start = 1'b0, valid = 1'b0;
   logic           start1, start16;
   logic [3*A-1:0] mul_a = '0;
   logic [3*B-1:0] mul_b = '0;
   logic [W-1:0]   pe_out = '0;
   logic           mis1, done1, pass1, mis16, done16, pass16;
   logic [7:0]     cmp1, err1, fe1, cmp16, err16, fe16;
   logic           mis, done, pass;
   logic [7:0]     cmp, err, fe;
   int             total = 0, bad = 0, nv = 16;

   int unsigned va [16][3];
   int unsigned vb [16][3];
   bit          corrupt [16];
   int          vcyc [16];

   always #5 clk = ~clk;

   assign start1  = start && nv == 1;
   assign start16 = start && nv != 1;

   pe_checker #(.A(A), .B(B), .LAT(LAT), .NUM_VEC(1)) dut1 (
      .i_clk(clk), .i_resetn(resetn), .i_start(start1), .i_valid(valid),
      .pe_mul_a(mul_a), .pe_mul_b(mul_b), .pe_out(pe_out),
      .o_mismatch(mis1), .o_cmp_cnt(cmp1), .o_err_cnt(err1),
      .o_done(done1), .o_pass(pass1), .o_first_err_idx(fe1)
   );

   pe_checker #(.A(A), .B(B), .LAT(LAT), .NUM_VEC(16)) dut16 (
      .i_clk(clk), .i_resetn(resetn), .i_start(start16), .i_valid(valid),
      .pe_mul_a(mul_a), .pe_mul_b(mul_b), .pe_out(pe_out),
      .o_mismatch(mis16), .o_cmp_cnt(cmp16), .o_err_cnt(err16),
      .o_done(done16), .o_pass(pass16), .o_first_err_idx(fe16)
   );

   always_comb begin
      mis  = nv == 1 ? mis1  : mis16;
      done = nv == 1 ? done1 : done16;
      pass = nv == 1 ? pass1 : pass16;
      cmp  = nv == 1 ? cmp1  : cmp16;
      err  = nv == 1 ? err1  : err16;
      fe   = nv == 1 ? fe1   : fe16;
   end

   function automatic int unsigned ref_exp(input int j);
      return va[j][0] * vb[j][0] + va[j][1] * vb[j][1] + va[j][2] * vb[j][2];
   endfunction

   // mode 0: back-to-back, 1: valid toggling 1/0, 2: random gaps of 0..2 cycles
   task automatic fill_random(input int n, input int mode);
      for (int j = 0; j < n; j++) begin
         for (int k = 0; k < 3; k++) begin
            va[j][k] = $urandom_range(0, 255);
            vb[j][k] = $urandom_range(0, 255);
         end
         corrupt[j] = 1'b0;
         vcyc[j] = mode == 0 ? j : mode == 1 ? 2 * j : (j == 0 ? 0 : vcyc[j-1] + 1 + int'($urandom_range(0, 2)));
      end
   endtask

   // Vector j is presented in cycle vcyc[j]; its result is driven LAT cycles later.
   task automatic run(input int n, input bit extra, input int mid_start, input int abort_c, input string name);
      int last, jv, jc, ecmp, eerr, efirst, want_fe;
      bit emis, edone;
      nv = n;
      start = 1'b1;
      valid = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      total++; if (cmp !== 8'd0 || err !== 8'd0 || done !== 1'b0) begin bad++; $display("FAIL %s start_clear got cmp=%0d err=%0d done=%0b want 0/0/0", name, cmp, err, done); end
      last = vcyc[n-1] + LAT;
      efirst = -1;
      for (int c = 0; c <= last + 3; c++) begin
         jv = -1;
         jc = -1;
         for (int j = 0; j < n; j++) begin
            if (vcyc[j] == c) jv = j;
            if (vcyc[j] + LAT == c) jc = j;
         end
         valid = jv >= 0 || (extra && c > vcyc[n-1]);
         start = c == mid_start;
         if (jv >= 0) begin
            mul_a = {va[jv][2][7:0], va[jv][1][7:0], va[jv][0][7:0]};
            mul_b = {vb[jv][2][7:0], vb[jv][1][7:0], vb[jv][0][7:0]};
         end else begin
            mul_a = 24'($urandom);
            mul_b = 24'($urandom);
         end
         pe_out = jc >= 0 ? W'(ref_exp(jc) - 32'(corrupt[jc])) : W'($urandom);
         if (c == abort_c) resetn = 1'b0;
         @(posedge clk); #1;
         start = 1'b0;
         if (c == abort_c) begin
            resetn = 1'b1;
            total++; if ({mis, done, pass} !== 3'b000 || cmp !== 8'd0 || err !== 8'd0 || fe !== 8'd0) begin bad++; $display("FAIL %s abort_clear got mis=%0b done=%0b pass=%0b cmp=%0d err=%0d fe=%0d want all 0", name, mis, done, pass, cmp, err, fe); end
            for (int k = 0; k < 3; k++) begin
               valid = 1'b1;
               mul_a = 24'($urandom);
               mul_b = 24'($urandom);
               pe_out = W'($urandom);
               @(posedge clk); #1;
               total++; if (cmp !== 8'd0 || mis !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL %s after_abort k=%0d got cmp=%0d mis=%0b done=%0b want 0/0/0", name, k, cmp, mis, done); end
            end
            valid = 1'b0;
            return;
         end
         ecmp = 0;
         eerr = 0;
         emis = 1'b0;
         for (int j = 0; j < n; j++) begin
            if (vcyc[j] + LAT <= c) begin
               ecmp++;
               if (corrupt[j]) begin
                  eerr++;
                  if (efirst < 0) efirst = j;
               end
            end
            if (vcyc[j] + LAT == c && corrupt[j]) emis = 1'b1;
         end
         edone = c >= last + 1;
         total++; if (cmp !== 8'(ecmp)) begin bad++; $display("FAIL %s cmp_cnt c=%0d got %0d want %0d", name, c, cmp, ecmp); end
         total++; if (err !== 8'(eerr)) begin bad++; $display("FAIL %s err_cnt c=%0d got %0d want %0d", name, c, err, eerr); end
         total++; if (mis !== emis) begin bad++; $display("FAIL %s mismatch c=%0d got %0b want %0b", name, c, mis, emis); end
         total++; if (done !== edone) begin bad++; $display("FAIL %s done c=%0d got %0b want %0b", name, c, done, edone); end
         total++; if (pass !== (edone && eerr == 0)) begin bad++; $display("FAIL %s pass c=%0d got %0b want %0b", name, c, pass, edone && eerr == 0); end
      end
      valid = 1'b0;
`ifdef PE_CHECKER_FIRST_ERR_EN
      want_fe = efirst < 0 ? 0 : efirst;
`else
      want_fe = 0;
`endif
      total++; if (fe !== 8'(want_fe)) begin bad++; $display("FAIL %s first_err_idx got %0d want %0d", name, fe, want_fe); end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      for (int k = 0; k < 3; k++) begin
         start = 1'($urandom);
         valid = 1'($urandom);
         mul_a = 24'($urandom);
         mul_b = 24'($urandom);
         @(posedge clk); #1;
      end
      start = 1'b0;
      valid = 1'b0;
      total++; if ({mis1, done1, pass1, mis16, done16, pass16} !== 6'b0) begin bad++; $display("FAIL reset flags got %06b want 000000", {mis1, done1, pass1, mis16, done16, pass16}); end
      total++; if ({cmp1, err1, fe1, cmp16, err16, fe16} !== 48'b0) begin bad++; $display("FAIL reset counts got %012h want 0", {cmp1, err1, fe1, cmp16, err16, fe16}); end
      resetn = 1'b1;
      valid = 1'b1;
      pe_out = W'($urandom);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         total++; if (cmp16 !== 8'd0 || done16 !== 1'b0 || mis16 !== 1'b0) begin bad++; $display("FAIL idle_ignores_valid got cmp=%0d done=%0b mis=%0b want 0/0/0", cmp16, done16, mis16); end
      end
      valid = 1'b0;
   endtask

   task automatic test_single();
      va[0] = '{1, 2, 3};
      vb[0] = '{4, 5, 6};
      vcyc[0] = 0;
      corrupt[0] = 1'b0;
      run(1, 1'b0, -1, -1, "single");
   endtask

   task automatic test_max_value();
      va[0] = '{255, 255, 255};
      vb[0] = '{255, 255, 255};
      vcyc[0] = 0;
      corrupt[0] = 1'b0;
      run(1, 1'b0, -1, -1, "max_ok");
      corrupt[0] = 1'b1;
      run(1, 1'b0, -1, -1, "max_bad");
   endtask

   task automatic test_bubbles();
      fill_random(16, 1);
      run(16, 1'b1, 3, -1, "bubbles");
   endtask

   task automatic test_back_to_back();
      fill_random(16, 0);
      for (int j = 0; j < 16; j++) corrupt[j] = $urandom_range(0, 3) == 0;
      run(16, 1'b1, -1, -1, "b2b_1");
      fill_random(16, 2);
      for (int j = 0; j < 16; j++) corrupt[j] = $urandom_range(0, 2) == 0;
      run(16, 1'b0, -1, -1, "b2b_2");
   endtask

   task automatic test_reset_mid_run();
      fill_random(16, 0);
      corrupt[1] = 1'b1;
      run(16, 1'b0, -1, 5, "abort");
      fill_random(16, 2);
      run(16, 1'b0, -1, -1, "after_abort");
   endtask

   task automatic test_first_err();
      fill_random(16, 2);
      corrupt[3] = 1'b1;
      corrupt[7] = 1'b1;
      run(16, 1'b0, -1, -1, "first_err");
   endtask

   initial begin
      test_reset();
      test_single();
      test_max_value();
      test_bubbles();
      test_back_to_back();
      test_reset_mid_run();
      test_first_err();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pe_checker.md
PE_CHECKER -- requirements
Module: pe_checker

Interface
REQ-001 Parameter A, default 8, operand-a lane width.
REQ-002 Parameter B, default 8, operand-b lane width.
REQ-003 Parameter LAT, default 2, PE input-to-out latency in cycles; legal range 1..8.
REQ-004 Parameter NUM_VEC, default 16, vectors per run; legal range 1..255.
REQ-005 Port i_clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 Port i_resetn  input  1  reset, synchronous, active-low.
REQ-007 Port i_start  input  1  one-cycle pulse that begins a run.
REQ-008 Port i_valid  input  1  pe_mul_a/pe_mul_b carry a vector this cycle.
REQ-009 Port pe_mul_a  input  3*A  three packed unsigned a lanes, lane0 = [A-1:0].
REQ-010 Port pe_mul_b  input  3*B  three packed unsigned b lanes, lane0 = [B-1:0].
REQ-011 Port pe_out  input  A+B+2  PE result under check.
REQ-012 Port o_mismatch  output  1  one-cycle pulse on a failed compare.
REQ-013 Port o_cmp_cnt  output  8  number of compares done in the current run.
REQ-014 Port o_err_cnt  output  8  number of mismatches, saturating at 255.
REQ-015 Port o_done  output  1  high when in DONE.
REQ-016 Port o_pass  output  1  high when in DONE and o_err_cnt == 0.
REQ-017 Port o_first_err_idx  output  8  o_cmp_cnt value at the first mismatch.

Function
REQ-018 The block SHALL compute exp = a0*b0 + a1*b1 + a2*b2 as an unsigned value, A+B+2 bits wide, with no truncation (max 195075 at defaults).
REQ-019 The block SHALL register exp and i_valid into a LAT-deep delay line, so that exp is presented for compare LAT cycles after its vector was accepted.
REQ-020 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-021 IDLE -> RUN on i_start; the move SHALL clear the counts, the delay line and the first-error capture.
REQ-022 In RUN, a vector SHALL be accepted only while i_valid=1 and accepted < NUM_VEC; i_valid SHALL be ignored outside RUN.
REQ-023 A compare SHALL occur when the delay-line tail valid bit = 1; pe_out != exp SHALL assert o_mismatch the same cycle (registered, visible the next cycle).
REQ-024 Each compare SHALL increment o_cmp_cnt, and each mismatch SHALL increment o_err_cnt, which saturates at 255.
REQ-025 RUN -> DONE SHALL happen the cycle after o_cmp_cnt reaches NUM_VEC.
REQ-026 The block SHALL stay in DONE until i_start, which re-enters RUN with cleared state.
REQ-027 i_start during RUN SHALL be ignored.
REQ-028 Gaps in i_valid SHALL be tolerated; the delay line carries bubbles and performs no compare on them.

Reset
REQ-029 While i_resetn=0 at a clock edge, the state SHALL go to IDLE and the delay line valid bits SHALL clear.
REQ-030 While i_resetn=0 at a clock edge, o_mismatch, o_cmp_cnt, o_err_cnt, o_done, o_pass and o_first_err_idx SHALL all go to 0.
REQ-031 Reset mid-RUN SHALL abort the run; in-flight expected values SHALL be discarded and never compared.

Configuration
REQ-032 With macro PE_CHECKER_FIRST_ERR_EN defined, the block SHALL latch o_first_err_idx on the first mismatch of a run and hold it until the next reset or i_start.
REQ-033 Without the macro, o_first_err_idx SHALL be tied to 0 and no capture register SHALL exist.

Structure
REQ-034 A shared package SHALL hold the A/B/LAT defaults, the derived out width A+B+2, and the FSM state encoding typedef.
REQ-035 Sub-module pe_ref_dot3 SHALL hold the combinational 3-lane dot product; the delay line, FSM and counters SHALL live in pe_checker.

Verification
REQ-036 Scenario: after reset, sample all outputs -> all equal 0, state IDLE.
REQ-037 Scenario: NUM_VEC=1, a=(1,2,3), b=(4,5,6), pe_out=32 at LAT -> o_cmp_cnt=1, o_err_cnt=0, then o_done=1 and o_pass=1.
REQ-038 Scenario: all lanes 255, pe_out=195075 -> pass; the same vector with pe_out=195074 -> o_mismatch pulse, o_err_cnt=1, o_pass=0.
REQ-039 Scenario: 16 vectors with i_valid toggling 1/0, all correct -> exactly 16 compares, no compare on bubbles, DONE reached.
REQ-040 Scenario: i_resetn=0 after 5 of 16 vectors -> everything 0 next cycle; i_start then restarts with o_cmp_cnt starting from 0.
REQ-041 Scenario: with PE_CHECKER_FIRST_ERR_EN, corrupt vectors 3 and 7 -> o_first_err_idx=3, o_err_cnt=2.
